branch_target_buffer: RTL and testbench

BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

---
 rtl/btb_pkg.sv | 19 +
 rtl/btb_way.sv | 59 +++++
 rtl/branch_target_buffer.sv | 165 ++++++++++++++++
 tb/tb_branch_target_buffer.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/btb_pkg.sv
// Shared BTB definitions: default geometry, tag-width derivation and the entry record.
package btb_pkg;

    localparam int SET_BITS_DEF = 6;
    localparam int TAG_W_MAX    = 30;

    // Tag bits remaining above the set index and the two byte-offset bits.
    function automatic int tag_width(input int set_bits);
        return 30 - set_bits;
    endfunction

    // The tag field is sized for the smallest geometry; ways keep only the low tag_width() bits.
    typedef struct packed {
        logic                 valid;
        logic [TAG_W_MAX-1:0] tag;
        logic [29:0]          target;
    } btb_entry;

endpackage

// File: rtl/btb_way.sv
// One BTB way: valid/tag/target storage, a fetch-side and an update-side tag compare, one write port.
module btb_way
    import btb_pkg::*;
#(
    parameter int SET_BITS = SET_BITS_DEF,
    parameter int TAG_W    = tag_width(SET_BITS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SET_BITS-1:0] lk_idx,
    input  logic [TAG_W-1:0]    lk_tag,
    output logic                lk_hit,
    output logic [31:0]         lk_target,
    input  logic [SET_BITS-1:0] up_idx,
    input  logic [TAG_W-1:0]    up_tag,
    output logic                up_hit,
    output logic                up_valid,
    input  logic                wr_en,
    input  logic [SET_BITS-1:0] wr_idx,
    input  btb_entry            wr_entry
);

    localparam int SETS = 1 << SET_BITS;

    logic [SETS-1:0]  valid_r;
    logic [TAG_W-1:0] tag_r    [SETS];
    logic [29:0]      target_r [SETS];
    logic             unused_s;

    assign unused_s = ^wr_entry;

    // Valid bits clear in a single cycle on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= '0;
        end else if (wr_en) begin
            valid_r[wr_idx] <= wr_entry.valid;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Tag and target arrays carry no reset; valid qualifies them.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_r[wr_idx]    <= wr_entry.tag[TAG_W-1:0];
            target_r[wr_idx] <= wr_entry.target;
        end
    end

    // Both compares read stored state only, so a same-cycle write is not bypassed.
    always_comb begin
        lk_hit    = valid_r[lk_idx] && (tag_r[lk_idx] == lk_tag);
        lk_target = {target_r[lk_idx], 2'b00};
        up_valid  = valid_r[up_idx];
        up_hit    = valid_r[up_idx] && (tag_r[up_idx] == up_tag);
    end

endmodule

// File: rtl/branch_target_buffer.sv
// Two-way set-associative branch target buffer with F lookup, M update, per-set LRU and F->D register.
// Optional build macro BTB_PERF_EN adds lookup_cnt/hit_cnt performance counters.
module branch_target_buffer
    import btb_pkg::*;
#(
    parameter int SET_BITS = SET_BITS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallD,
    input  logic        flushD,
    input  logic [31:0] pcF,
    output logic        btb_hitF,
    output logic [31:0] btb_targetF,
    output logic        btb_hitD,
    output logic [31:0] btb_targetD,
    input  logic [31:0] pcM,
    input  logic        branchM,
    input  logic        actual_takeM,
    input  logic [31:0] targetM
`ifdef BTB_PERF_EN
    ,
    output logic [31:0] lookup_cnt,
    output logic [31:0] hit_cnt
`endif
);

    localparam int SETS  = 1 << SET_BITS;
    localparam int TAG_W = tag_width(SET_BITS);

    logic [SET_BITS-1:0] lk_idx_s;
    logic [TAG_W-1:0]    lk_tag_s;
    logic [SET_BITS-1:0] up_idx_s;
    logic [TAG_W-1:0]    up_tag_s;
    logic [1:0]          hit_f_s;
    logic [31:0]         target_f_s [2];
    logic [1:0]          hit_m_s;
    logic [1:0]          valid_m_s;
    logic [1:0]          wr_en_s;
    btb_entry            wr_entry_s;
    logic                wr_way_s;
    logic                hit_way_s;
    logic                lru_we_s;
    logic                lru_val_s;
    logic [SETS-1:0]     lru_r;
    logic                unused_s;

    assign lk_idx_s = pcF[SET_BITS+1:2];
    assign lk_tag_s = pcF[31:SET_BITS+2];
    assign up_idx_s = pcM[SET_BITS+1:2];
    assign up_tag_s = pcM[31:SET_BITS+2];
    assign unused_s = ^{pcF[1:0], pcM[1:0], targetM[1:0]};

    for (genvar w = 0; w < 2; w++) begin : g_way
        btb_way #(
            .SET_BITS (SET_BITS),
            .TAG_W    (TAG_W)
        ) u_way (
            .clk       (clk),
            .rst       (rst),
            .lk_idx    (lk_idx_s),
            .lk_tag    (lk_tag_s),
            .lk_hit    (hit_f_s[w]),
            .lk_target (target_f_s[w]),
            .up_idx    (up_idx_s),
            .up_tag    (up_tag_s),
            .up_hit    (hit_m_s[w]),
            .up_valid  (valid_m_s[w]),
            .wr_en     (wr_en_s[w]),
            .wr_idx    (up_idx_s),
            .wr_entry  (wr_entry_s)
        );
    end

    // Fetch-side select: way 0 wins if both ways ever match.
    always_comb begin
        btb_hitF    = 1'b0;
        btb_targetF = 32'h0000_0000;
        if (hit_f_s[0]) begin
            btb_hitF    = 1'b1;
            btb_targetF = target_f_s[0];
        end else if (hit_f_s[1]) begin
            btb_hitF    = 1'b1;
            btb_targetF = target_f_s[1];
        end else begin
            btb_hitF    = 1'b0;
            btb_targetF = 32'h0000_0000;
        end
    end

    // Update decision: refresh a hit way, otherwise allocate an invalid way before evicting the LRU way.
    always_comb begin
        wr_en_s           = 2'b00;
        wr_way_s          = 1'b0;
        lru_we_s          = 1'b0;
        lru_val_s         = 1'b0;
        hit_way_s         = hit_m_s[0] ? 1'b0 : 1'b1;
        wr_entry_s.valid  = 1'b1;
        wr_entry_s.tag    = TAG_W_MAX'(up_tag_s);
        wr_entry_s.target = targetM[31:2];
        if (rst || !branchM) begin
            lru_we_s = 1'b0;
        end else if (actual_takeM) begin
            if (hit_m_s != 2'b00) begin
                wr_way_s = hit_way_s;
            end else if (!valid_m_s[0]) begin
                wr_way_s = 1'b0;
            end else if (!valid_m_s[1]) begin
                wr_way_s = 1'b1;
            end else begin
                wr_way_s = lru_r[up_idx_s];
            end
            wr_en_s[wr_way_s] = 1'b1;
            lru_we_s          = 1'b1;
            lru_val_s         = ~wr_way_s;
        end else if (hit_m_s != 2'b00) begin
            lru_we_s  = 1'b1;
            lru_val_s = ~hit_way_s;
        end else begin
            lru_we_s = 1'b0;
        end
    end

    // Per-set LRU bit names the way to evict next.
    always_ff @(posedge clk) begin
        if (rst) begin
            lru_r <= '0;
        end else if (lru_we_s) begin
            lru_r[up_idx_s] <= lru_val_s;
        end else begin
            lru_r <= lru_r;
        end
    end

    // F->D pipeline register; flush takes priority over stall.
    always_ff @(posedge clk) begin
        if (rst || flushD) begin
            btb_hitD    <= 1'b0;
            btb_targetD <= 32'h0000_0000;
        end else if (stallD) begin
            btb_hitD    <= btb_hitD;
            btb_targetD <= btb_targetD;
        end else begin
            btb_hitD    <= btb_hitF;
            btb_targetD <= btb_targetF;
        end
    end

`ifdef BTB_PERF_EN
    // Counters advance on each D-register load and wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            lookup_cnt <= 32'd0;
            hit_cnt    <= 32'd0;
        end else if (!stallD && !flushD) begin
            lookup_cnt <= lookup_cnt + 32'd1;
            hit_cnt    <= btb_hitF ? (hit_cnt + 32'd1) : hit_cnt;
        end else begin
            lookup_cnt <= lookup_cnt;
            hit_cnt    <= hit_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed bench for branch_target_buffer: per-cycle expectations queued at drive time, popped at output time.
module tb_branch_target_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallD;
    logic        flushD;
    logic [31:0] pcF;
    logic        btb_hitF;
    logic [31:0] btb_targetF;
    logic        btb_hitD;
    logic [31:0] btb_targetD;
    logic [31:0] pcM;
    logic        branchM;
    logic        actual_takeM;
    logic [31:0] targetM;

    typedef struct packed {
        logic        hit;
        logic [31:0] tgt;
    } exp_t;

    exp_t fq[$];
    exp_t dq[$];
    exp_t d_model;
    int   vectors_applied = 0;
    int   miscompares     = 0;

    branch_target_buffer dut (
        .clk          (clk),
        .rst          (rst),
        .stallD       (stallD),
        .flushD       (flushD),
        .pcF          (pcF),
        .btb_hitF     (btb_hitF),
        .btb_targetF  (btb_targetF),
        .btb_hitD     (btb_hitD),
        .btb_targetD  (btb_targetD),
        .pcM          (pcM),
        .branchM      (branchM),
        .actual_takeM (actual_takeM),
        .targetM      (targetM)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input string nm, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors_applied++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s %s: observed %h expected %h", nm, tag, obs, exp_v);
        end
    endtask

    // One cycle: check last cycle's D result, drive inputs, queue expectations, check F mid-cycle.
    task automatic cyc(input string nm, input logic r, input logic [31:0] pf,
                       input logic st, input logic fl,
                       input logic br, input logic tk, input logic [31:0] pm, input logic [31:0] tm,
                       input logic fchk, input logic eh, input logic [31:0] et);
        exp_t e;
        @(posedge clk);
        #1;
        if (dq.size() > 0) begin
            e = dq.pop_front();
            check("hitD", nm, {31'd0, btb_hitD}, {31'd0, e.hit});
            check("targetD", nm, btb_targetD, e.tgt);
        end
        rst          = r;
        pcF          = pf;
        stallD       = st;
        flushD       = fl;
        branchM      = br;
        actual_takeM = tk;
        pcM          = pm;
        targetM      = tm;
        if (r || fl) begin
            d_model = '{hit: 1'b0, tgt: 32'h0};
        end else if (!st) begin
            d_model = '{hit: eh, tgt: et};
        end
        dq.push_back(d_model);
        if (fchk) fq.push_back('{hit: eh, tgt: et});
        @(negedge clk);
        if (fq.size() > 0) begin
            e = fq.pop_front();
            check("hitF", nm, {31'd0, btb_hitF}, {31'd0, e.hit});
            check("targetF", nm, btb_targetF, e.tgt);
        end
    endtask

    initial begin
        exp_t e;
        rst = 1'b1; stallD = 1'b0; flushD = 1'b0; pcF = 32'h0; pcM = 32'h0;
        branchM = 1'b0; actual_takeM = 1'b0; targetM = 32'h0;
        d_model = '{hit: 1'b0, tgt: 32'h0};
        repeat (2) @(posedge clk);

        //   name      rst   pcF           st    fl    br    tk    pcM           targetM       chk   hit   target
        cyc("rst_upd", 1'b1, 32'h00400010, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00400010, 32'h00400100, 1'b0, 1'b0, 32'h0);
        cyc("postrst", 1'b0, 32'h00400010, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 32'h0);
        cyc("updA",    1'b0, 32'h00400010, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00400010, 32'h00400100, 1'b1, 1'b0, 32'h0);
        cyc("hitA",    1'b0, 32'h00400010, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b1, 32'h00400100);
        cyc("updB",    1'b0, 32'h00401010, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00401010, 32'h00401200, 1'b1, 1'b0, 32'h0);
        cyc("updC",    1'b0, 32'h00401010, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00402010, 32'h00402300, 1'b1, 1'b1, 32'h00401200);
        cyc("evictA",  1'b0, 32'h00400010, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 32'h0);
        cyc("hitB",    1'b0, 32'h00401010, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b1, 32'h00401200);
        cyc("hitC",    1'b0, 32'h00402010, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b1, 32'h00402300);
        cyc("samecyc", 1'b0, 32'h00400020, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00400020, 32'h00400446, 1'b1, 1'b0, 32'h0);
        cyc("nextcyc", 1'b0, 32'h00400020, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b1, 32'h00400444);
        cyc("ntHit",   1'b0, 32'h00400020, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00400020, 32'h00409990, 1'b1, 1'b1, 32'h00400444);
        cyc("ntKeep",  1'b0, 32'h00400020, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b1, 32'h00400444);
        cyc("ntMiss",  1'b0, 32'h00403030, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00403030, 32'h00403800, 1'b1, 1'b0, 32'h0);
        cyc("ntNoAlc", 1'b0, 32'h00403030, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 32'h0);
        cyc("ntLruB",  1'b0, 32'h00401010, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00401010, 32'h0,        1'b1, 1'b1, 32'h00401200);
        cyc("updD",    1'b0, 32'h00402010, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00403010, 32'h00403500, 1'b1, 1'b1, 32'h00402300);
        cyc("evictC",  1'b0, 32'h00402010, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 32'h0);
        cyc("keepB",   1'b0, 32'h00401010, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b1, 32'h00401200);
        cyc("hitD_",   1'b0, 32'h00403010, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b1, 32'h00403500);
        cyc("retgtB",  1'b0, 32'h00401010, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00401010, 32'h00401800, 1'b1, 1'b1, 32'h00401200);
        cyc("newtgtB", 1'b0, 32'h00401010, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b1, 32'h00401800);
        cyc("stall1",  1'b0, 32'h00403010, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b1, 32'h00403500);
        cyc("stall2",  1'b0, 32'h00400010, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 32'h0);
        cyc("flushst", 1'b0, 32'h00403010, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b1, 32'h00403500);
        cyc("reload",  1'b0, 32'h00403010, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b1, 32'h00403500);
        cyc("b2b_1",   1'b0, 32'h00400050, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00400050, 32'h11110000, 1'b1, 1'b0, 32'h0);
        cyc("b2b_2",   1'b0, 32'h00400050, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00400054, 32'h22220000, 1'b1, 1'b1, 32'h11110000);
        cyc("b2b_chk", 1'b0, 32'h00400054, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b1, 32'h22220000);
        cyc("midrst",  1'b1, 32'h00400054, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0);
        cyc("gone1",   1'b0, 32'h00401010, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 32'h0);
        cyc("gone2",   1'b0, 32'h00400054, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 32'h0);

        @(posedge clk);
        #1;
        while (dq.size() > 0) begin
            e = dq.pop_front();
            check("hitD", "final", {31'd0, btb_hitD}, {31'd0, e.hit});
            check("targetD", "final", btb_targetD, e.tgt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
